// File: rtl/div_unit.sv
// div_unit: multi-cycle signed/unsigned restoring divider, one quotient bit per clock
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic             a_neg, b_neg, borrow;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    always_comb begin
        a_neg   = is_signed & dividend[WIDTH-1];
        b_neg   = is_signed & divisor[WIDTH-1];
        shifted = {rem_q, dvd_q[WIDTH-1]};
        // shifted < 2*divisor, so when no borrow the difference fits in WIDTH bits
        borrow  = shifted < {1'b0, dsr_q};
        trial   = shifted[WIDTH-1:0] - dsr_q;
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = dividend;
                    dbz_d   = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    dvd_d   = a_neg ? -dividend : dividend;
                    dsr_d   = b_neg ? -divisor : divisor;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                dvd_d   = {dvd_q[WIDTH-2:0], ~borrow};
                rem_d   = borrow ? shifted[WIDTH-1:0] : trial;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
            end
            FIX: begin
                quo_d   = qneg_q ? -dvd_q : dvd_q;
                rmd_d   = rneg_q ? -rem_q : rem_q;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
        end
    end
    assign busy        = state_q == RUN || state_q == FIX;
    assign done        = state_q == DONE;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random divides checked against a queued reference model
module tb_div_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        int          nb;
    } exp_t;
    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    function automatic exp_t model(logic s, logic [31:0] a, logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa, sd;
        sa    = a;
        sd    = b;
        e.z   = 1'b0;
        e.lat = 34;
        e.nb  = 33;
        if (b == 0) begin
            e.q = '1; e.r = a; e.z = 1'b1; e.lat = 1; e.nb = 0;
        end else if (!s) begin
            e.q = a / b; e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0;
        end else begin
            e.q = sa / sd; e.r = sa % sd;
        end
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit sync);
        if (sync) @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        sb.push_back(model(s, a, b));
        @(posedge clk);
    endtask
    task automatic collect(input string tag, input int poke_k);
        exp_t e;
        int k = 1, nb = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && k < 100) begin
            if (busy) nb++;
            if (k == poke_k) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd999; divisor = 32'd5;
            end else start = 1'b0;
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, k, e.lat);
        chk({tag, " busy cycles"}, nb, e.nb);
        chk({tag, " quotient"}, quotient, e.q);
        chk({tag, " remainder"}, remainder, e.r);
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.z});
    endtask
    initial begin
        logic [31:0] a, b;
        logic        s;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div_by_zero", {31'd0, div_by_zero}, 0);
        rst_n = 1'b1;
        issue(0, 32'd100, 32'd7, 1); collect("u 100/7", 0);
        @(negedge clk);
        chk("done one cycle", {31'd0, done}, 0);
        issue(1, -32'sd7, 32'd2, 1); collect("s -7/2", 0);
        issue(1, 32'd7, -32'sd2, 1); collect("s 7/-2", 0);
        issue(0, 32'hFFFF_FFFF, 32'd1, 1); collect("u max/1", 0);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1); collect("s min/-1", 0);
        issue(0, 32'h1234, 32'd0, 1); collect("div0", 0);
        issue(0, 32'd50, 32'd5, 1); collect("flag clear", 0);
        issue(0, 32'd1000, 32'd3, 1); collect("midrun start", 10);
        @(negedge clk);
        chk("start not queued busy", {31'd0, busy}, 0);
        chk("start not queued done", {31'd0, done}, 0);
        issue(1, -32'sd100, 32'd7, 1); collect("b2b first", 0);
        issue(0, 32'd77, 32'd8, 0); collect("b2b second", 0);
        issue(0, 32'hDEAD_BEEF, 32'd3, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", {31'd0, busy}, 0);
        chk("midrun reset done", {31'd0, done}, 0);
        chk("midrun reset quotient", quotient, 0);
        chk("midrun reset remainder", remainder, 0);
        chk("midrun reset div_by_zero", {31'd0, div_by_zero}, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 32'd12345, 32'd67, 1); collect("post reset", 0);
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            issue(s, a, b, 1); collect("random", 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
